// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_LEN_LO = 3'd2,
        S_LEN_HI = 3'd3,
        S_DATA   = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA9;
    localparam int         LEN_WIDTH         = 16;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return s inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Shifts incoming bytes (MSB first) into a DataWidth word and flags the byte
// that completes each word.
module program_loader_word_assembler #(
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data_byte,
    input  logic                 strobe,
    input  logic                 clear,
    output logic [DataWidth-1:0] word,
    output logic                 word_complete
);

    localparam int Bpw      = DataWidth / 8;
    localparam int IdxWidth = (Bpw > 1) ? $clog2(Bpw) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Bpw - 1);

    logic [IdxWidth-1:0] idx;

    assign word_complete = strobe && (idx == LastIdx);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (strobe) begin
            word <= (word << 8) | DataWidth'(data_byte);
            idx  <= word_complete ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes words into program memory from address 0
// and releases the CPU only after a complete, checksum-verified load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         DataWidth = 16,
    parameter int         AddrWidth = 8,
    parameter logic [7:0] SyncByte  = DEFAULT_SYNC_BYTE
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [7:0]           RX_Data,
    input  logic                 RX_Valid,
    output logic                 RX_Ready,
    output logic [AddrWidth-1:0] MEM_Addr,
    output logic [DataWidth-1:0] MEM_DIn,
    output logic                 MEM_WE,
    output logic                 CPU_Reset,
    output logic                 Done,
    output logic                 Error
);

    localparam logic [LEN_WIDTH:0] MaxLen = (LEN_WIDTH + 1)'(2 ** AddrWidth);

    state_t               state, state_next;
    logic                 accept;
    logic                 start_ok;
    logic [7:0]           len_lo;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH:0]   len_rx;
    logic [LEN_WIDTH:0]   word_cnt;
    logic [7:0]           checksum;
    logic                 asm_strobe;
    logic                 asm_clear;
    logic                 word_complete;

    assign RX_Ready   = accepts_bytes(state);
    assign accept     = RX_Valid && RX_Ready;
    assign start_ok   = Start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign len_rx     = {1'b0, RX_Data, len_lo};
    assign asm_strobe = accept && (state == S_DATA);
    assign asm_clear  = start_ok || (accept && (state == S_LEN_HI));

    program_loader_word_assembler #(
        .DataWidth(DataWidth)
    ) u_word_assembler (
        .clk          (Clk),
        .rst_n        (Reset),
        .data_byte    (RX_Data),
        .strobe       (asm_strobe),
        .clear        (asm_clear),
        .word         (MEM_DIn),
        .word_complete(word_complete)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (Start) state_next = S_SYNC;
            S_SYNC:   if (accept && (RX_Data == SyncByte)) state_next = S_LEN_LO;
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_rx > MaxLen)  state_next = S_ERROR;
                    else if (len_rx == '0) state_next = S_CHECK;
                    else                   state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_complete && (word_cnt + 1'b1 == {1'b0, len}))
                    state_next = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_next = (RX_Data == checksum) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            checksum  <= '0;
            MEM_Addr  <= '0;
            MEM_WE    <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            CPU_Reset <= 1'b0;
        end else begin
            MEM_WE    <= word_complete;
            Done      <= (state_next == S_DONE);
            Error     <= (state_next == S_ERROR);
            CPU_Reset <= (state_next == S_DONE);

            if (start_ok) checksum <= '0;

            // Step past a written word unless it was the last one of the frame.
            if (MEM_WE && (word_cnt != {1'b0, len})) MEM_Addr <= MEM_Addr + AddrWidth'(1);

            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo <= RX_Data;
                    S_LEN_HI: begin
                        len <= len_rx[LEN_WIDTH-1:0];
                        if (state_next == S_DATA) begin
                            word_cnt <= '0;
                            checksum <= '0;
                            MEM_Addr <= '0;
                        end
                    end
                    S_DATA: begin
                        checksum <= checksum + RX_Data;
                        if (word_complete) word_cnt <= word_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame table plus hand-written timing,
// noise, length-bound, mid-load reset and restart sequences.
module tb_program_loader;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    RX_Data = '0;
    logic          RX_Valid = 1'b0;
    logic          RX_Ready;
    logic [AW-1:0] MEM_Addr;
    logic [DW-1:0] MEM_DIn;
    logic          MEM_WE;
    logic          CPU_Reset;
    logic          Done;
    logic          Error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [256];
    int          wr_cnt    = 0;
    int          last_addr = -1;
    int          base;

    typedef struct {
        string       name;
        int          n;
        logic [79:0] bytes;
        logic        done;
        logic        err;
        int          writes;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs [6];

    always #5 Clk = ~Clk;

    program_loader #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .RX_Data  (RX_Data),
        .RX_Valid (RX_Valid),
        .RX_Ready (RX_Ready),
        .MEM_Addr (MEM_Addr),
        .MEM_DIn  (MEM_DIn),
        .MEM_WE   (MEM_WE),
        .CPU_Reset(CPU_Reset),
        .Done     (Done),
        .Error    (Error)
    );

    // Memory model: records every write strobe, sampled mid-cycle.
    always @(negedge Clk) begin
        if (MEM_WE === 1'b1) begin
            mem[MEM_Addr] = MEM_DIn;
            wr_cnt        = wr_cnt + 1;
            last_addr     = int'(MEM_Addr);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge Clk);
        RX_Data  = b;
        RX_Valid = 1'b1;
        while (!RX_Ready && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (!RX_Ready) begin
            n_checks++;
            $display("FAIL send_byte_timeout: RX_Ready got 0, expected 1 (byte %0h)", b);
            RX_Valid = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
            RX_Valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic send_nominal();
        send_byte(8'hA9); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        send_byte(8'hCD); send_byte(8'hBE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Checksum of payload 12 34 AB CD is 0xBE (mod-256 sum).
        vecs[0] = '{"nominal",   8, 80'hA9_02_00_12_34_AB_CD_BE_00_00, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
        vecs[1] = '{"bad_chk",   8, 80'hA9_02_00_12_34_AB_CD_BF_00_00, 1'b0, 1'b1, 2, 16'h1234, 16'hABCD};
        vecs[2] = '{"len0",      4, 80'hA9_00_00_00_00_00_00_00_00_00, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[3] = '{"len0_bad",  4, 80'hA9_00_00_01_00_00_00_00_00_00, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[4] = '{"len_0x101", 3, 80'hA9_01_01_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[5] = '{"one_word",  6, 80'hA9_01_00_00_FF_FF_00_00_00_00, 1'b1, 1'b0, 1, 16'h00FF, 16'h0000};

        // Reset state.
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_rx_ready",  32'(RX_Ready),  32'd0);
        check("rst_mem_we",    32'(MEM_WE),    32'd0);
        check("rst_mem_addr",  32'(MEM_Addr),  32'd0);
        check("rst_mem_din",   32'(MEM_DIn),   32'd0);
        check("rst_cpu_reset", 32'(CPU_Reset), 32'd0);
        check("rst_done",      32'(Done),      32'd0);
        check("rst_error",     32'(Error),     32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Frame table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            base = wr_cnt;
            pulse_start();
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[79 - 8*k -: 8]);
            check({vecs[i].name, "_done"},      32'(Done),      32'(vecs[i].done));
            check({vecs[i].name, "_error"},     32'(Error),     32'(vecs[i].err));
            check({vecs[i].name, "_cpu_reset"}, 32'(CPU_Reset), 32'(vecs[i].done));
            check({vecs[i].name, "_rx_ready"},  32'(RX_Ready),  32'd0);
            @(negedge Clk);
            check({vecs[i].name, "_writes"}, 32'(wr_cnt - base), 32'(vecs[i].writes));
            if (vecs[i].writes >= 1) check({vecs[i].name, "_w0"}, 32'(mem[0]), 32'(vecs[i].w0));
            if (vecs[i].writes >= 2) check({vecs[i].name, "_w1"}, 32'(mem[1]), 32'(vecs[i].w1));
        end

        // Cycle-level write timing with back-to-back bytes.
        do_reset();
        pulse_start();
        send_byte(8'hA9); send_byte(8'h02); send_byte(8'h00); send_byte(8'h12);
        check("tim_we_mid_word", 32'(MEM_WE), 32'd0);
        send_byte(8'h34);
        check("tim_we0",   32'(MEM_WE),   32'd1);
        check("tim_addr0", 32'(MEM_Addr), 32'd0);
        check("tim_din0",  32'(MEM_DIn),  32'h1234);
        send_byte(8'hAB);
        check("tim_we_gap",  32'(MEM_WE),   32'd0);
        check("tim_addr_inc", 32'(MEM_Addr), 32'd1);
        send_byte(8'hCD);
        check("tim_we1",   32'(MEM_WE),   32'd1);
        check("tim_addr1", 32'(MEM_Addr), 32'd1);
        check("tim_din1",  32'(MEM_DIn),  32'hABCD);
        check("tim_done_early", 32'(Done), 32'd0);
        send_byte(8'hBE);
        check("tim_we_off",   32'(MEM_WE),    32'd0);
        check("tim_addr_hold", 32'(MEM_Addr), 32'd1);
        check("tim_done",     32'(Done),      32'd1);
        check("tim_cpu_rel",  32'(CPU_Reset), 32'd1);

        // Restart from DONE.
        pulse_start();
        check("restart_done",      32'(Done),      32'd0);
        check("restart_cpu_reset", 32'(CPU_Reset), 32'd0);
        check("restart_rx_ready",  32'(RX_Ready),  32'd1);
        base = wr_cnt;
        send_byte(8'hA9); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hAD);
        check("restart_done2", 32'(Done), 32'd1);
        @(negedge Clk);
        check("restart_writes", 32'(wr_cnt - base), 32'd1);
        check("restart_w0",     32'(mem[0]),        32'hBEEF);

        // Noise before sync and 3-cycle gaps between payload bytes.
        do_reset();
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
        send_byte(8'hA9); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h12); idle(3); send_byte(8'h34); idle(3);
        send_byte(8'hAB); idle(3); send_byte(8'hCD); idle(3);
        send_byte(8'hBE);
        check("noise_done",  32'(Done),  32'd1);
        check("noise_error", 32'(Error), 32'd0);
        @(negedge Clk);
        check("noise_writes", 32'(wr_cnt - base), 32'd2);
        check("noise_w0",     32'(mem[0]),        32'h1234);
        check("noise_w1",     32'(mem[1]),        32'hABCD);

        // Maximum length: 256 words of {i, ~i}, each contributing 0xFF -> checksum 0x00.
        do_reset();
        base = wr_cnt;
        pulse_start();
        send_byte(8'hA9); send_byte(8'h00); send_byte(8'h01);
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w));
            send_byte(~8'(w));
        end
        send_byte(8'h00);
        check("max_done",      32'(Done),     32'd1);
        check("max_error",     32'(Error),    32'd0);
        check("max_addr_hold", 32'(MEM_Addr), 32'hFF);
        @(negedge Clk);
        check("max_writes",    32'(wr_cnt - base), 32'd256);
        check("max_last_addr", 32'(last_addr),     32'hFF);
        check("max_w128",      32'(mem[128]),      32'h807F);

        // Reset mid-load, after the first word is written.
        do_reset();
        base = wr_cnt;
        pulse_start();
        send_byte(8'hA9); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("mid_rst_we",        32'(MEM_WE),    32'd0);
        check("mid_rst_addr",      32'(MEM_Addr),  32'd0);
        check("mid_rst_din",       32'(MEM_DIn),   32'd0);
        check("mid_rst_done",      32'(Done),      32'd0);
        check("mid_rst_error",     32'(Error),     32'd0);
        check("mid_rst_cpu_reset", 32'(CPU_Reset), 32'd0);
        check("mid_rst_rx_ready",  32'(RX_Ready),  32'd0);
        @(negedge Clk);
        Reset    = 1'b1;
        RX_Data  = 8'hA9;
        RX_Valid = 1'b1;
        idle(4);
        check("mid_rst_idle_ready",  32'(RX_Ready),       32'd0);
        check("mid_rst_writes_kept", 32'(wr_cnt - base),  32'd1);
        RX_Valid = 1'b0;
        base = wr_cnt;
        pulse_start();
        send_nominal();
        check("mid_rst_reload_done", 32'(Done), 32'd1);
        @(negedge Clk);
        check("mid_rst_reload_writes", 32'(wr_cnt - base), 32'd2);
        check("mid_rst_reload_w0",     32'(mem[0]),        32'h1234);
        check("mid_rst_reload_w1",     32'(mem[1]),        32'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
